// File: rtl/snac_db15_reader_if.sv
// Signals between the SNAC DB15 reader and the adapter pins and button consumers.
// The master modport is the reader's side of these signals.
interface snac_db15_reader_if;
    logic        enable;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;
    logic        osd_combo;

    modport master (
        input  enable, joy_data,
        output joy_clk, joy_load, joystick1, joystick2, frame_done, osd_combo
    );

    modport slave (
        output enable, joy_data,
        input  joy_clk, joy_load, joystick1, joystick2, frame_done, osd_combo
    );
endinterface

// File: rtl/snac_db15_reader.sv
// Serial reader for the SNAC DB15 adapter (two chained PISO registers, 12 buttons/player).
// Outputs change only after two consecutive identical frames.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | inter-frame gap, strobes idle high, gap counter running
//   ST_LOAD     | joy_load low for 2*CLK_DIV cycles (parallel load)
//   ST_SHIFT_LO | joy_clk low half period, sample on its last cycle
//   ST_SHIFT_HI | joy_clk high half period, adapter advances one bit
//   ST_DONE     | frame complete, compare with previous frame and commit
module snac_db15_reader #(
    parameter int CLK_DIV    = 16,
    parameter int GAP_CYCLES = 1024,
    parameter int NBITS      = 24
) (
    input  logic               clk_sys,
    input  logic               reset,
    snac_db15_reader_if.master bus
);
    localparam int PBITS = NBITS / 2;
    localparam int PW    = $clog2(2 * CLK_DIV);
    localparam int BW    = $clog2(NBITS + 1);

    localparam logic [PW-1:0] LOAD_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_DONE
    } state_t;

    state_t state, state_next;

    logic             data_meta, data_sync;
    logic [15:0]      gap_cnt;
    logic [PW-1:0]    phase_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [NBITS-1:0] frame_bits;
    logic [NBITS-1:0] prev_frame;
    logic [PBITS-1:0] joy1, joy2;
    logic             frame_done, osd_combo;
    logic             joy_clk, joy_load;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= bus.joy_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (gap_cnt == GAP_LAST) state_next = ST_LOAD;
                ST_LOAD:     if (phase_cnt == LOAD_LAST) state_next = ST_SHIFT_LO;
                ST_SHIFT_LO: if (phase_cnt == PHASE_LAST) state_next = ST_SHIFT_HI;
                ST_SHIFT_HI: if (phase_cnt == PHASE_LAST)
                                 state_next = (bit_cnt == BIT_LAST) ? ST_DONE : ST_SHIFT_LO;
                ST_DONE:     state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        joy_clk  = 1'b1;
        joy_load = 1'b1;
        case (state)
            ST_LOAD:     joy_load = 1'b0;
            ST_SHIFT_LO: joy_clk  = 1'b0;
            default:     ;
        endcase
    end

    // Timers restart on every state change; the bit index survives LO/HI toggling.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            gap_cnt    <= '0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            frame_bits <= '0;
            prev_frame <= '0;
            joy1       <= '0;
            joy2       <= '0;
            frame_done <= 1'b0;
            osd_combo  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            gap_cnt    <= (bus.enable && state == ST_IDLE && state_next == ST_IDLE)
                          ? gap_cnt + 16'd1 : '0;
            phase_cnt  <= (state_next == state &&
                           (state == ST_LOAD || state == ST_SHIFT_LO || state == ST_SHIFT_HI))
                          ? phase_cnt + PW'(1) : '0;

            if (state == ST_LOAD)
                bit_cnt <= '0;
            else if (state == ST_SHIFT_HI && phase_cnt == PHASE_LAST)
                bit_cnt <= bit_cnt + BW'(1);

            if (state == ST_SHIFT_LO && phase_cnt == PHASE_LAST)
                frame_bits[bit_cnt] <= ~data_sync;

            if (!bus.enable) begin
                prev_frame <= '0;
                joy1       <= '0;
                joy2       <= '0;
                osd_combo  <= 1'b0;
            end else begin
                osd_combo <= joy1[8] & joy1[6];
                if (state == ST_DONE) begin
                    prev_frame <= frame_bits;
                    frame_done <= 1'b1;
                    if (frame_bits == prev_frame) begin
                        joy1 <= frame_bits[PBITS-1:0];
                        joy2 <= frame_bits[NBITS-1:PBITS];
                    end
                end
            end
        end
    end

    assign bus.joy_clk    = joy_clk;
    assign bus.joy_load   = joy_load;
    assign bus.joystick1  = {{(16 - PBITS){1'b0}}, joy1};
    assign bus.joystick2  = {{(16 - PBITS){1'b0}}, joy2};
    assign bus.frame_done = frame_done;
    assign bus.osd_combo  = osd_combo;
endmodule

// File: tb/tb_snac_db15_reader.sv
// Self-checking bench for snac_db15_reader: adapter shift-register model plus a
// frame-level reference of the two-frame agreement filter.
module tb_snac_db15_reader;
    logic clk_sys = 1'b0;
    logic reset;
    logic reset2;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk_sys = ~clk_sys;

    snac_db15_reader_if bus1 ();
    snac_db15_reader_if bus2 ();

    snac_db15_reader dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus1)
    );

    snac_db15_reader #(.CLK_DIV(4)) dut4 (
        .clk_sys (clk_sys),
        .reset   (reset2),
        .bus     (bus2)
    );

    // Adapter: 24-bit PISO chain, bit 0 presented after load, advances on joy_clk rise.
    logic [23:0] adapter_word = '0;
    logic        adapter_present = 1'b0;
    int          adp_idx = 24;
    bit          adp_prev_clk = 1'b1;

    always @(negedge clk_sys) begin
        if (bus1.joy_load === 1'b0)
            adp_idx = 0;
        else if (bus1.joy_clk === 1'b1 && !adp_prev_clk)
            adp_idx = adp_idx + 1;
        adp_prev_clk = (bus1.joy_clk === 1'b1);
        bus1.joy_data = (adapter_present && adp_idx < 24) ? ~adapter_word[adp_idx] : 1'b1;
    end

    // Reference: last frame seen and committed 24-bit word.
    logic [23:0] m_prev   = '0;
    logic [23:0] m_commit = '0;

    task automatic model_frame(input logic [23:0] w);
        if (w == m_prev) m_commit = w;
        m_prev = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        cyc++;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus1.joy_load === 1'b0;
            1:       return bus1.frame_done === 1'b1;
            2:       return bus2.joy_load === 1'b0;
            default: return bus2.frame_done === 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int which, input int limit, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < limit) begin
            tick();
            n++;
            hit = sig(which);
        end
        check(tag, hit, 1'b1);
    endtask

    task automatic run_frame(input logic [23:0] w, output int fd_cyc);
        int   bad;
        logic hit;
        logic old_osd;
        adapter_word = w;
        bad = 0;
        hit = 1'b0;
        old_osd = m_commit[8] & m_commit[6];
        for (int i = 0; i < 4000 && !hit; i++) begin
            tick();
            if (bus1.frame_done === 1'b1)
                hit = 1'b1;
            else if (bus1.joystick1 !== {4'h0, m_commit[11:0]} ||
                     bus1.joystick2 !== {4'h0, m_commit[23:12]})
                bad++;
        end
        fd_cyc = cyc;
        check("frame_done_seen", hit, 1'b1);
        check("outputs_held_between_frames", bad, 0);
        model_frame(w);
        check("joystick1_at_frame_done", bus1.joystick1, {4'h0, m_commit[11:0]});
        check("joystick2_at_frame_done", bus1.joystick2, {4'h0, m_commit[23:12]});
        check("osd_combo_lags_commit", bus1.osd_combo, old_osd);
        tick();
        check("frame_done_one_cycle", bus1.frame_done, 1'b0);
        check("osd_combo_after_commit", bus1.osd_combo, m_commit[8] & m_commit[6]);
    endtask

    initial begin
        int n, lc, pulses, bad_w, w, falls, fd, prev_fd, c0, stray;
        logic fd_seen, pclk;
        logic [23:0] word_a, word_b;

        reset = 1'b1;
        reset2 = 1'b1;
        bus1.enable = 1'b0;
        bus2.enable = 1'b0;
        bus2.joy_data = 1'b0;
        repeat (3) tick();

        check("rst_joy_clk", bus1.joy_clk, 1'b1);
        check("rst_joy_load", bus1.joy_load, 1'b1);
        check("rst_joystick1", bus1.joystick1, 16'h0000);
        check("rst_joystick2", bus1.joystick2, 16'h0000);
        check("rst_frame_done", bus1.frame_done, 1'b0);
        check("rst_osd_combo", bus1.osd_combo, 1'b0);

        // Adapter absent: frame timing with line floating high.
        reset = 1'b0;
        bus1.enable = 1'b1;
        cyc = 0;
        wait_cond("first_load_timeout", 0, 3000, n);
        check("first_load_fall_cycle", n, 1024);
        lc = 0;
        for (int i = 0; i < 100 && bus1.joy_load === 1'b0; i++) begin
            lc++;
            tick();
        end
        check("load_low_cycles", lc, 32);
        pulses = 0; bad_w = 0; w = 0; fd_seen = 1'b0;
        for (int i = 0; i < 1500 && !fd_seen; i++) begin
            if (bus1.joy_clk === 1'b0) w++;
            else if (w != 0) begin
                pulses++;
                if (w != 16) bad_w++;
                w = 0;
            end
            if (bus1.frame_done === 1'b1) fd_seen = 1'b1;
            else tick();
        end
        check("frame_done_seen_first", fd_seen, 1'b1);
        check("clk_pulse_count", pulses, 24);
        check("clk_pulse_widths_bad", bad_w, 0);
        check("first_frame_done_cycle", cyc, 1825);
        model_frame(24'h0);
        check("absent_joystick1", bus1.joystick1, 16'h0000);
        check("absent_joystick2", bus1.joystick2, 16'h0000);
        prev_fd = cyc;
        tick();
        run_frame(24'h0, fd);
        check("frame_period", fd - prev_fd, 1825);

        // Adapter present: two-frame agreement.
        adapter_present = 1'b1;
        word_a = {12'h0A0, 12'h015};
        prev_fd = fd;
        run_frame(word_a, fd);
        check("frame_period_present", fd - prev_fd, 1825);
        check("no_commit_after_one_frame", bus1.joystick1, 16'h0000);
        run_frame(word_a, fd);
        check("commit_joystick1", bus1.joystick1, 16'h0015);
        check("commit_joystick2", bus1.joystick2, 16'h00A0);

        // One corrupted frame must never reach the outputs.
        run_frame(word_a ^ 24'h000008, fd);
        check("corrupt_held_joystick1", bus1.joystick1, 16'h0015);
        run_frame(word_a, fd);
        check("after_corrupt_joystick1", bus1.joystick1, 16'h0015);
        run_frame(word_a, fd);
        check("recommit_joystick1", bus1.joystick1, 16'h0015);

        // OSD combo: buttons 8 and 6, then release 6.
        word_b = {12'h00F, 12'h140};
        run_frame(word_b, fd);
        run_frame(word_b, fd);
        check("osd_joystick1", bus1.joystick1, 16'h0140);
        check("osd_combo_set", bus1.osd_combo, 1'b1);
        word_b = {12'h00F, 12'h100};
        run_frame(word_b, fd);
        run_frame(word_b, fd);
        check("osd_combo_clear", bus1.osd_combo, 1'b0);

        // Randomized frames with repeats and occasional single-bit glitches.
        for (int k = 0; k < 5; k++) begin
            logic [23:0] rw;
            int reps;
            rw = 24'($urandom);
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                if (r == 1 && $urandom_range(0, 3) == 0)
                    run_frame(rw ^ (24'h1 << $urandom_range(0, 23)), fd);
                else
                    run_frame(rw, fd);
            end
        end

        // Enable abort at bit 10 of SHIFT.
        word_a = 24'h5A3C81;
        run_frame(word_a, fd);
        run_frame(word_a, fd);
        check("pre_abort_joystick1", bus1.joystick1, 16'h0C81);
        wait_cond("abort_load_timeout", 0, 3000, n);
        pclk = 1'b1;
        falls = 0;
        for (int i = 0; i < 2000 && falls < 11; i++) begin
            tick();
            if (pclk && bus1.joy_clk === 1'b0) falls++;
            pclk = (bus1.joy_clk === 1'b1);
        end
        check("reached_bit10", falls, 11);
        repeat (5) tick();
        bus1.enable = 1'b0;
        tick();
        m_prev = '0;
        m_commit = '0;
        check("abort_joy_clk", bus1.joy_clk, 1'b1);
        check("abort_joy_load", bus1.joy_load, 1'b1);
        check("abort_joystick1", bus1.joystick1, 16'h0000);
        check("abort_joystick2", bus1.joystick2, 16'h0000);
        check("abort_osd_combo", bus1.osd_combo, 1'b0);
        stray = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus1.frame_done !== 1'b0 || bus1.joy_load !== 1'b1) stray++;
            tick();
        end
        check("disabled_no_activity", stray, 0);
        word_a = 24'h3C5A81;
        adapter_word = word_a;
        bus1.enable = 1'b1;
        wait_cond("reenable_load_timeout", 0, 3000, n);
        check("reenable_load_fall_cycle", n, 1024);
        run_frame(word_a, fd);
        check("reenable_first_frame_joystick1", bus1.joystick1, 16'h0000);
        run_frame(word_a, fd);
        check("reenable_commit_joystick1", bus1.joystick1, 16'h0A81);

        // CLK_DIV=4 instance: all buttons pressed, reset during LOAD.
        reset2 = 1'b0;
        bus2.enable = 1'b1;
        wait_cond("d4_fd1_timeout", 3, 3000, n);
        check("d4_first_frame_cycle", n, 1225);
        check("d4_no_commit_frame1", bus2.joystick1, 16'h0000);
        wait_cond("d4_fd2_timeout", 3, 3000, n);
        check("d4_frame_period", n, 1225);
        check("d4_commit_joystick1", bus2.joystick1, 16'h0FFF);
        check("d4_commit_joystick2", bus2.joystick2, 16'h0FFF);
        tick();
        check("d4_osd_combo", bus2.osd_combo, 1'b1);
        wait_cond("d4_load_timeout", 2, 3000, n);
        repeat (3) tick();
        check("d4_in_load", bus2.joy_load, 1'b0);
        reset2 = 1'b1;
        tick();
        check("d4_rst_joy_clk", bus2.joy_clk, 1'b1);
        check("d4_rst_joy_load", bus2.joy_load, 1'b1);
        check("d4_rst_joystick1", bus2.joystick1, 16'h0000);
        check("d4_rst_joystick2", bus2.joystick2, 16'h0000);
        check("d4_rst_frame_done", bus2.frame_done, 1'b0);
        check("d4_rst_osd_combo", bus2.osd_combo, 1'b0);
        reset2 = 1'b0;
        c0 = cyc;
        wait_cond("d4_post_rst_load_timeout", 2, 3000, n);
        check("d4_post_rst_load_cycle", n, 1024);
        wait_cond("d4_post_rst_fd_timeout", 3, 3000, n);
        check("d4_post_rst_frame_cycle", cyc - c0, 1225);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snac_db15_reader.md
Name: snac_db15_reader

Overview:
- Serial reader for the SNAC DB15 joystick adapter: two daisy-chained parallel-in/serial-out shift registers, 12 buttons per player.
- Sits directly upstream of the top-level joystick mux and generates the adapter's JOY_CLK/JOY_LOAD strobes.
- Samples JOY_DATA (USER_IN[5]) and delivers filtered, active-high button words for player 1 and player 2.
- Those words feed the joystick mux, joy_raw and the USER_OSD combo.

Parameters:
- CLK_DIV, 16, clk_sys cycles per half shift-clock period; legal range 4..255.
- GAP_CYCLES, 1024, idle clk_sys cycles between frames; legal range 1..65535.
- NBITS, 24, bits per frame: 12 per player, player 1 first.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning enable; driven from OR of status[31:30].
- joy_data  in  1  serial data from the adapter, active-low buttons, asynchronous.
- joy_clk  out  1  shift clock to the adapter.
- joy_load  out  1  parallel-load strobe, active-low.
- joystick1  out  16  player 1 buttons, active-high; [11:0] valid, [15:12]=0.
- joystick2  out  16  player 2 buttons, active-high; [11:0] valid, [15:12]=0.
- frame_done  out  1  one-cycle pulse at the end of every completed frame.
- osd_combo  out  1  joystick1[8] & joystick1[6].

Behaviour:
- Reset values: joy_clk=1, joy_load=1, joystick1=0, joystick2=0, frame_done=0, osd_combo=0. State=IDLE, counters=0, previous-frame register=0.
- Input sync: joy_data passes a 2-flop synchronizer, reset value 1. All sampling uses the synchronized signal.
- IDLE: joy_clk=1, joy_load=1. Count GAP_CYCLES cycles, then go to LOAD. If enable=0, stay in IDLE with the counter held at 0.
- LOAD: joy_load=0, joy_clk=1 for 2*CLK_DIV cycles, then go to SHIFT with bit index 0.
- SHIFT, per bit i = 0..NBITS-1:
  - Low phase: joy_clk=0 for CLK_DIV cycles. On the last cycle of the low phase, capture b[i] = synchronized joy_data.
  - High phase: joy_clk=1 for CLK_DIV cycles.
  - After the high phase of bit NBITS-1, go to DONE.
- DONE (1 cycle):
  - Form frame word F[i] = ~b[i].
  - If F equals the previous-frame register, commit: joystick1[11:0] = F[11:0], joystick2[11:0] = F[23:12].
  - Always load the previous-frame register with F. Pulse frame_done=1. Go to IDLE.
- Frame length: GAP_CYCLES + 2*CLK_DIV + NBITS*2*CLK_DIV + 1 cycles. With defaults this is 1825 cycles.
- Two-frame agreement filter: a change is committed only after 2 consecutive identical frames. One corrupted frame never reaches the outputs.
- Output updates are atomic: both joystick words change in the same cycle as the frame_done pulse, and never otherwise.
- osd_combo is registered from the committed joystick1, so it updates 1 cycle after the commit.
- enable dropping to 0 in any state:
  - Abort the frame next cycle: joy_clk=1, joy_load=1, state=IDLE.
  - Clear the outputs and the previous-frame register to 0. No frame_done pulse.
  - When enable returns to 1, a full GAP_CYCLES elapses before LOAD.
- reset mid-frame behaves identically to the reset values above, with immediate effect.
- Adapter absent (line floats high): every F=0, so the outputs settle at 0.
- Bit counter and phase counter are sized for NBITS and CLK_DIV with no wrap inside a frame. The gap counter is 16 bits.

Test Plan:
- Reset, then enable=1 with joy_data=1 held: after reset all outputs are 0; first joy_load falling edge at cycle GAP_CYCLES (1024); joy_load low 32 cycles; 24 joy_clk low pulses of 16 cycles each; frame_done pulses every 1825 cycles; outputs remain 0.
- Adapter model driving player1=12'h015 and player2=12'h0A0, active-low, repeated frames: no change after frame 1; after frame 2, joystick1=16'h0015 and joystick2=16'h00A0, updating in the frame_done cycle.
- Steady 16'h0015 on joystick1, then one frame with bit 3 flipped, then good frames: outputs never show 16'h001D and stay 16'h0015 throughout.
- Player 1 buttons 8 and 6 pressed (12'h140) for 2 frames: joystick1=16'h0140 and osd_combo=1 one cycle after the commit. Releasing button 6 for 2 frames gives osd_combo=0.
- enable deasserted at bit 10 of SHIFT: next cycle joy_clk=1, joy_load=1, joystick1=joystick2=0, no frame_done. Re-enable: joy_load falls exactly 1024 cycles later.
- Synchronous reset asserted during LOAD with CLK_DIV=4: all outputs at their reset values on the following cycle. Frame timing after release is 1024+8+192+1=1225 cycles.
